// File: rtl/check_window_ctrl_if.sv
// Handshake and result bundle for check_window_ctrl.
// The slave side is the controller and the master side is its user.
interface check_window_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail;
    logic             fail_seen;
    logic             aborted;

    modport master (
        output start, win_len, a, b,
        input  busy, done, pass_cnt, fail_cnt, first_fail, fail_seen, aborted
    );

    modport slave (
        input  start, win_len, a, b,
        output busy, done, pass_cnt, fail_cnt, first_fail, fail_seen, aborted
    );
endinterface

// File: rtl/check_window_ctrl.sv
// Check-window controller: samples a && b once per cycle for win_len cycles,
// counting passes and fails, with optional early abort after FAIL_LIMIT fails.
module check_window_ctrl #(
    parameter int CNT_W      = 8,
    parameter int FAIL_LIMIT = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    check_window_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    localparam bit               ABORT_EN = (FAIL_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(FAIL_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail;
    logic             fail_seen;
    logic             aborted;
    logic             sample_ok;
    logic             limit_hit;
    logic             last_sample;

    assign sample_ok   = bus.a && bus.b;
    assign limit_hit   = ABORT_EN && !sample_ok && ((fail_cnt + 1'b1) == LIMIT);
    assign last_sample = (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.win_len == '0) ? REPORT : RUN;
                end
            end
            RUN: begin
                if (limit_hit || last_sample) begin
                    state_nxt = REPORT;
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done decode only the state register, so they stay registered outputs.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == REPORT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining  <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining  <= bus.win_len;
                        idx        <= '0;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        aborted    <= 1'b0;
                    end
                end
                RUN: begin
                    remaining <= remaining - 1'b1;
                    idx       <= idx + 1'b1;
                    if (sample_ok) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        fail_cnt <= fail_cnt + 1'b1;
                        if (!fail_seen) begin
                            first_fail <= idx;
                            fail_seen  <= 1'b1;
                        end
                        if (limit_hit) begin
                            aborted <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pass_cnt   = pass_cnt;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.first_fail = first_fail;
    assign bus.fail_seen  = fail_seen;
    assign bus.aborted    = aborted;
endmodule

// File: tb/tb_check_window_ctrl.sv
// Directed and randomized bench for check_window_ctrl against a window-level
// reference model computed from the pass/fail/abort rules.
module tb_check_window_ctrl;
    localparam int CNT_W      = 8;
    localparam int FAIL_LIMIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   pat_a[$];
    bit   pat_b[$];

    check_window_ctrl_if #(.CNT_W(CNT_W)) bus ();

    check_window_ctrl #(
        .CNT_W      (CNT_W),
        .FAIL_LIMIT (FAIL_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input int ep, input int ef,
                                 input int ff, input int fs, input int ab);
        check({tag, ".pass_cnt"},   32'(bus.pass_cnt),   32'(ep));
        check({tag, ".fail_cnt"},   32'(bus.fail_cnt),   32'(ef));
        check({tag, ".first_fail"}, 32'(bus.first_fail), 32'(ff));
        check({tag, ".fail_seen"},  32'(bus.fail_seen),  32'(fs));
        check({tag, ".aborted"},    32'(bus.aborted),    32'(ab));
    endtask

    // Runs one window of n cycles using pat_a/pat_b; ends one cycle after done (IDLE).
    task automatic run_window(input string tag, input int n, input bit hold);
        int ep = 0, ef = 0, ff = 0, fs = 0, ab = 0, nsamp = 0;
        for (int i = 0; i < n; i++) begin
            nsamp++;
            if (pat_a[i] && pat_b[i]) ep++;
            else begin
                if (fs == 0) ff = i;
                fs = 1;
                ef++;
                if (FAIL_LIMIT != 0 && ef == FAIL_LIMIT) begin
                    ab = 1;
                    break;
                end
            end
        end

        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_len = CNT_W'(n);
        bus.a       = 1'($urandom);
        bus.b       = 1'($urandom);
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        bus.win_len = CNT_W'($urandom);
        check({tag, ".accept_busy"}, 32'(bus.busy), 32'd1);
        check({tag, ".accept_done"}, 32'(bus.done), 32'(n == 0));
        check_results({tag, ".cleared"}, 0, 0, 0, 0, 0);

        for (int k = 0; k < nsamp; k++) begin
            bus.a = pat_a[k];
            bus.b = pat_b[k];
            @(posedge clk); #1;
            check({tag, ".done_k"}, 32'(bus.done), 32'(k == nsamp - 1));
            check({tag, ".busy_k"}, 32'(bus.busy), 32'd1);
        end
        check_results({tag, ".report"}, ep, ef, ff, fs, ab);

        bus.a = 1'($urandom);
        bus.b = 1'($urandom);
        @(posedge clk); #1;
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".idle_done"}, 32'(bus.done), 32'd0);
        check_results({tag, ".held"}, ep, ef, ff, fs, ab);
    endtask

    task automatic set_pattern(input int n, input int mode);
        pat_a.delete();
        pat_b.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin pat_a.push_back(1'b1); pat_b.push_back(1'b1); end
                1: begin pat_a.push_back(!(i == 1 || i == 3)); pat_b.push_back(1'b1); end
                2: begin pat_a.push_back(1'b0); pat_b.push_back(1'b0); end
                default: begin
                    pat_a.push_back($urandom_range(0, 3) != 0);
                    pat_b.push_back($urandom_range(0, 3) != 0);
                end
            endcase
        end
    endtask

    initial begin
        bus.start   = 1'b1;
        bus.win_len = CNT_W'(4);
        bus.a       = 1'b1;
        bus.b       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check_results("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        check("post_reset.busy", 32'(bus.busy), 32'd0);

        set_pattern(5, 0);
        run_window("all_pass", 5, 1'b0);
        set_pattern(6, 1);
        run_window("two_fail", 6, 1'b0);
        set_pattern(10, 2);
        run_window("abort", 10, 1'b0);
        set_pattern(0, 0);
        run_window("zero_len", 0, 1'b0);

        // Back-to-back: start held high through the first window and into the next.
        set_pattern(4, 1);
        run_window("b2b_first", 4, 1'b1);
        set_pattern(3, 0);
        run_window("b2b_second", 3, 1'b0);

        // Start pulsed mid-run, then reset at idx 2 of an 8-cycle window.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_len = CNT_W'(8);
        bus.a       = 1'b0;
        bus.b       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_run.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_run.busy", 32'(bus.busy), 32'd0);
        check("rst_run.done", 32'(bus.done), 32'd0);
        check_results("rst_run", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("rst_run.no_done", 32'(bus.done), 32'd0);
            check("rst_run.no_busy", 32'(bus.busy), 32'd0);
        end

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 12);
            set_pattern(n, 3);
            run_window($sformatf("rand%0d", r), n, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/check_window_ctrl.md
CHECK_WINDOW_CTRL -- requirements
Module: check_window_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of window length, counters and fail index.
REQ-002 The block SHALL have parameter FAIL_LIMIT, default 3: fail count that aborts a window; 0 disables abort.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 The block SHALL have port start  input  1  request to open a check window; honoured only in IDLE.
REQ-006 The block SHALL have port win_len  input  CNT_W  number of cycles to check, captured with start.
REQ-007 The block SHALL have ports a, b  input  1 each  monitored signals; a cycle passes when a && b.
REQ-008 The block SHALL have port busy  output  1  high in RUN and REPORT.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse in REPORT.
REQ-010 The block SHALL have ports pass_cnt, fail_cnt  output  CNT_W each  per-window pass and fail totals.
REQ-011 The block SHALL have port first_fail  output  CNT_W  0-based window index of the first failing cycle.
REQ-012 The block SHALL have ports fail_seen, aborted  output  1 each  any failure seen; window ended early by FAIL_LIMIT.
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and REPORT.
REQ-015 IDLE, start=1, win_len!=0 at edge T: SHALL clear all result outputs, load remaining=win_len, idx=0, and enter RUN.
REQ-016 IDLE, start=1, win_len==0: SHALL clear results and enter REPORT directly (zero counts, fail_seen=0, aborted=0).
REQ-017 RUN: each edge SHALL sample a && b once; pass increments pass_cnt, fail increments fail_cnt; idx increments and remaining decrements.
REQ-018 On the first failure of a window, first_fail SHALL take the current idx and fail_seen SHALL be set; later failures SHALL NOT change first_fail.
REQ-019 first_fail SHALL be 0 when fail_seen=0 and SHALL be qualified only by fail_seen.
REQ-020 With win_len=N accepted at edge T, samples SHALL occur at edges T+1..T+N and REPORT SHALL be entered at edge T+N.
REQ-021 done SHALL be high for exactly the cycle between edges T+N and T+N+1, and the FSM SHALL return to IDLE at edge T+N+1.
REQ-022 If FAIL_LIMIT!=0 and a sample makes fail_cnt equal FAIL_LIMIT, that sample SHALL be the last; the FSM SHALL set aborted and enter REPORT on the same edge.
REQ-023 Abort and last-window-sample on the same edge SHALL enter REPORT with aborted=1.
REQ-024 start SHALL be ignored in RUN and REPORT; no queuing.
REQ-025 start in the IDLE cycle directly after REPORT SHALL be accepted normally.
REQ-026 Results SHALL hold after done until the next accepted start; no counter overflow is possible because pass_cnt + fail_cnt <= win_len <= 2^CNT_W-1.
REQ-027 win_len, a and b SHALL be ignored outside their defined sampling points.

Reset
REQ-028 With rst_n=0 at a posedge, the FSM SHALL enter IDLE, and busy, done, pass_cnt, fail_cnt, first_fail, fail_seen and aborted SHALL all be 0.
REQ-029 Reset during RUN or REPORT SHALL abandon the window without a done pulse.
REQ-030 start SHALL be ignored while rst_n=0.

Verification
REQ-031 The bench SHALL cover: win_len=5, a=b=1 throughout -> done exactly 5 cycles after start is accepted; pass_cnt=5, fail_cnt=0, fail_seen=0, aborted=0.
REQ-032 The bench SHALL cover: win_len=6, FAIL_LIMIT=3, a=0 on idx 1 and 3 only -> pass_cnt=4, fail_cnt=2, first_fail=1, aborted=0.
REQ-033 The bench SHALL cover: win_len=10, FAIL_LIMIT=3, a=b=0 throughout -> done after 3 samples; fail_cnt=3, pass_cnt=0, first_fail=0, aborted=1.
REQ-034 The bench SHALL cover: win_len=0 -> done one cycle after start, busy high for 1 cycle, all counts 0.
REQ-035 The bench SHALL cover: start pulsed in RUN, then rst_n=0 at idx 2 of an 8-cycle window -> no second window, no done, all outputs 0 on the next cycle.
REQ-036 The bench SHALL cover: back-to-back windows with start held high -> second window accepted in the IDLE cycle after done; results cleared at acceptance.
